// File: rtl/nway_request_tracker.sv
// nway_request_tracker: DEPTH-entry outstanding-request table with lowest-slot
// allocation, lowest-slot issue, out-of-order retirement by address,
// optional coalescing of allocations into unissued entries, and address lookup.
module nway_request_tracker #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 17,
  parameter bit          COALESCE    = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid_i,
  output logic                         alloc_ready_o,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr_i,
  input  logic [INDEX_WIDTH-1:0]       alloc_index_i,
  input  logic                         alloc_hit_i,
  output logic                         alloc_merged_o,
  output logic                         issue_valid_o,
  input  logic                         issue_ready_i,
  output logic [ADDR_WIDTH-1:0]        issue_addr_o,
  output logic [INDEX_WIDTH-1:0]       issue_index_o,
  output logic [$clog2(DEPTH)-1:0]     issue_slot_o,
  input  logic                         retire_valid_i,
  input  logic [ADDR_WIDTH-1:0]        retire_addr_i,
  output logic                         retire_ack_o,
  output logic                         retire_err_o,
  output logic [INDEX_WIDTH-1:0]       retire_index_o,
  output logic                         retire_hit_o,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr_i,
  output logic                         lookup_hit_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned SLOT_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_PROC    = 2'd2
  } slot_state_t;

  slot_state_t             state_q [DEPTH];
  slot_state_t             state_d [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_q  [DEPTH];
  logic [INDEX_WIDTH-1:0]  index_q [DEPTH];
  logic                    hit_q   [DEPTH];
  logic [CNT_W-1:0]        occ_q;

  logic                    free_found;
  logic [SLOT_W-1:0]       free_slot;
  logic                    pend_found;
  logic [SLOT_W-1:0]       pend_slot;
  logic [ADDR_WIDTH-1:0]   pend_addr;
  logic [INDEX_WIDTH-1:0]  pend_index;
  logic                    ret_found;
  logic [SLOT_W-1:0]       ret_slot;
  logic [INDEX_WIDTH-1:0]  ret_index;
  logic                    ret_hit;
  logic                    lookup_match;
  logic                    merge_found;
  logic                    issue_fire;
  logic                    alloc_fire;
  logic                    alloc_merge;
  logic                    alloc_write;
  logic                    retire_fire;

  // Priority searches over the slot table as it stood at the start of the cycle
  always_comb begin
    free_found   = 1'b0;
    free_slot    = '0;
    pend_found   = 1'b0;
    pend_slot    = '0;
    pend_addr    = '0;
    pend_index   = '0;
    ret_found    = 1'b0;
    ret_slot     = '0;
    ret_index    = '0;
    ret_hit      = 1'b0;
    lookup_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!free_found && state_q[i] == SLOT_FREE) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
      if (!pend_found && state_q[i] == SLOT_PENDING) begin
        pend_found = 1'b1;
        pend_slot  = SLOT_W'(i);
        pend_addr  = addr_q[i];
        pend_index = index_q[i];
      end
      if (!ret_found && state_q[i] == SLOT_PROC && addr_q[i] == retire_addr_i) begin
        ret_found = 1'b1;
        ret_slot  = SLOT_W'(i);
        ret_index = index_q[i];
        ret_hit   = hit_q[i];
      end
      if (state_q[i] != SLOT_FREE && addr_q[i] == lookup_addr_i) begin
        lookup_match = 1'b1;
      end
    end
  end

  // Coalescing candidate: an unissued same-address slot not leaving PENDING this cycle
  always_comb begin
    merge_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (COALESCE && state_q[i] == SLOT_PENDING && addr_q[i] == alloc_addr_i &&
          !(issue_fire && pend_slot == SLOT_W'(i))) begin
        merge_found = 1'b1;
      end
    end
  end

  // Handshake qualification
  always_comb begin
    issue_fire    = pend_found && issue_ready_i;
    alloc_ready_o = !full_o || merge_found;
    alloc_fire    = alloc_valid_i && alloc_ready_o;
    alloc_merge   = alloc_fire && merge_found;
    alloc_write   = alloc_fire && !merge_found && free_found;
    retire_fire   = retire_valid_i && ret_found;
  end

  // Per-slot next state; alloc, issue and retire always target distinct slots
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      if (alloc_write && free_slot == SLOT_W'(i)) state_d[i] = SLOT_PENDING;
      if (issue_fire && pend_slot == SLOT_W'(i))  state_d[i] = SLOT_PROC;
      if (retire_fire && ret_slot == SLOT_W'(i))  state_d[i] = SLOT_FREE;
    end
  end

  // Slot state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) state_q[i] <= SLOT_FREE;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
    end
  end

  // Slot payload captured on a non-merged allocation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        index_q[i] <= '0;
        hit_q[i]   <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc_write && free_slot == SLOT_W'(i)) begin
          addr_q[i]  <= alloc_addr_i;
          index_q[i] <= alloc_index_i;
          hit_q[i]   <= alloc_hit_i;
        end
      end
    end
  end

  // Occupancy counter and registered response pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q          <= '0;
      alloc_merged_o <= 1'b0;
      retire_ack_o   <= 1'b0;
      retire_err_o   <= 1'b0;
      retire_index_o <= '0;
      retire_hit_o   <= 1'b0;
      lookup_hit_o   <= 1'b0;
    end else begin
      case ({alloc_write, retire_fire})
        2'b10:   occ_q <= occ_q + CNT_W'(1);
        2'b01:   occ_q <= occ_q - CNT_W'(1);
        default: occ_q <= occ_q;
      endcase
      alloc_merged_o <= alloc_merge;
      retire_ack_o   <= retire_fire;
      retire_err_o   <= retire_valid_i && !ret_found;
      retire_index_o <= retire_fire ? ret_index : '0;
      retire_hit_o   <= retire_fire && ret_hit;
      lookup_hit_o   <= lookup_match;
    end
  end

  // Issue port and status flags driven straight from state
  always_comb begin
    issue_valid_o = pend_found;
    issue_addr_o  = pend_addr;
    issue_index_o = pend_index;
    issue_slot_o  = pend_slot;
    occupancy_o   = occ_q;
    full_o        = (occ_q == CNT_W'(DEPTH));
    empty_o       = (occ_q == '0);
  end

endmodule

// File: tb/tb_nway_request_tracker.sv
// Randomized scoreboard bench for nway_request_tracker: one instance without and
// one with coalescing, both driven by the same stimulus and each predicted by
// its own slot-table reference model.
module tb_nway_request_tracker;

  localparam int NCYC = 1600;

  typedef struct packed {
    logic        issue_valid;
    logic [31:0] issue_addr;
    logic [16:0] issue_index;
    logic [2:0]  issue_slot;
    logic [3:0]  occupancy;
    logic        full;
    logic        empty;
    logic        alloc_ready;
    logic        merged;
    logic        ack;
    logic        err;
    logic [16:0] rindex;
    logic        rhit;
    logic        lookup;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [31:0] alloc_addr;
  logic [16:0] alloc_index;
  logic        alloc_hit;
  logic        issue_ready;
  logic        retire_valid;
  logic [31:0] retire_addr;
  logic [31:0] lookup_addr;

  logic [1:0]  alloc_ready, alloc_merged, issue_valid, retire_ack, retire_err;
  logic [1:0]  retire_hit, lookup_hit, full, empty;
  logic [31:0] issue_addr   [2];
  logic [16:0] issue_index  [2];
  logic [16:0] retire_index [2];
  logic [2:0]  issue_slot   [2];
  logic [3:0]  occupancy    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nway_request_tracker #(
      .DEPTH(8), .ADDR_WIDTH(32), .INDEX_WIDTH(17), .COALESCE(g == 1)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_valid_i  (alloc_valid),
      .alloc_ready_o  (alloc_ready[g]),
      .alloc_addr_i   (alloc_addr),
      .alloc_index_i  (alloc_index),
      .alloc_hit_i    (alloc_hit),
      .alloc_merged_o (alloc_merged[g]),
      .issue_valid_o  (issue_valid[g]),
      .issue_ready_i  (issue_ready),
      .issue_addr_o   (issue_addr[g]),
      .issue_index_o  (issue_index[g]),
      .issue_slot_o   (issue_slot[g]),
      .retire_valid_i (retire_valid),
      .retire_addr_i  (retire_addr),
      .retire_ack_o   (retire_ack[g]),
      .retire_err_o   (retire_err[g]),
      .retire_index_o (retire_index[g]),
      .retire_hit_o   (retire_hit[g]),
      .lookup_addr_i  (lookup_addr),
      .lookup_hit_o   (lookup_hit[g]),
      .occupancy_o    (occupancy[g]),
      .full_o         (full[g]),
      .empty_o        (empty[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Reference model: per-instance slot table
  bit          m_occ  [2][8];
  bit          m_proc [2][8];
  logic [31:0] m_addr [2][8];
  logic [16:0] m_idx  [2][8];
  bit          m_hit  [2][8];

  // Responses expected one cycle after their request
  bit          nx_merged [2];
  bit          nx_ack    [2];
  bit          nx_err    [2];
  logic [16:0] nx_rindex [2];
  bit          nx_rhit   [2];
  bit          nx_lookup [2];

  task automatic chk(input string name, input int inst, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=0x%0h expected=0x%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pool_addr(input int unsigned k);
    return 32'((k + 1) * 32'h100);
  endfunction

  // Stimulus and prediction: drive #1 after each rising edge, push the expected view
  initial begin : driver
    exp_t        e;
    int          pend, rslot, fslot, cnt;
    bit          merge, fire, ifire, lk, rst_now, fill;
    logic [31:0] pa[$];

    rst = 1'b1;
    alloc_valid = 1'b0; alloc_addr = '0; alloc_index = '0; alloc_hit = 1'b0;
    issue_ready = 1'b0; retire_valid = 1'b0; retire_addr = '0; lookup_addr = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      rst_now = (cyc < 3) || (cyc >= 900 && cyc < 902);
      rst     = rst_now;
      fill    = ((cyc / 80) % 2) == 0;

      pa.delete();
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 8; i++)
          if (m_occ[c][i] && m_proc[c][i]) pa.push_back(m_addr[c][i]);

      alloc_valid  = !rst_now && ($urandom_range(99) < (fill ? 75 : 25));
      alloc_addr   = pool_addr($urandom_range(6));
      alloc_index  = 17'($urandom);
      alloc_hit    = 1'($urandom_range(1));
      issue_ready  = ($urandom_range(99) < 60);
      retire_valid = !rst_now && ($urandom_range(99) < (fill ? 25 : 70));
      if (pa.size() > 0 && $urandom_range(3) != 0)
        retire_addr = pa[$urandom_range(pa.size() - 1)];
      else
        retire_addr = pool_addr($urandom_range(7));
      lookup_addr  = pool_addr($urandom_range(7));

      for (int c = 0; c < 2; c++) begin
        if (rst_now) begin
          for (int i = 0; i < 8; i++) begin
            m_occ[c][i] = 1'b0; m_proc[c][i] = 1'b0;
          end
          nx_merged[c] = 1'b0; nx_ack[c] = 1'b0; nx_err[c] = 1'b0;
          nx_rindex[c] = '0;   nx_rhit[c] = 1'b0; nx_lookup[c] = 1'b0;
        end

        pend = -1;
        cnt  = 0;
        for (int i = 0; i < 8; i++) begin
          if (pend < 0 && m_occ[c][i] && !m_proc[c][i]) pend = i;
          if (m_occ[c][i]) cnt++;
        end
        ifire = (pend >= 0) && issue_ready;
        merge = 1'b0;
        if (c == 1)
          for (int i = 0; i < 8; i++)
            if (m_occ[c][i] && !m_proc[c][i] && m_addr[c][i] == alloc_addr &&
                !(ifire && i == pend)) merge = 1'b1;

        e.issue_valid = (pend >= 0);
        e.issue_addr  = (pend >= 0) ? m_addr[c][pend] : 32'h0;
        e.issue_index = (pend >= 0) ? m_idx[c][pend] : 17'h0;
        e.issue_slot  = (pend >= 0) ? 3'(pend) : 3'h0;
        e.occupancy   = 4'(cnt);
        e.full        = (cnt == 8);
        e.empty       = (cnt == 0);
        e.alloc_ready = (cnt != 8) || merge;
        e.merged      = nx_merged[c];
        e.ack         = nx_ack[c];
        e.err         = nx_err[c];
        e.rindex      = nx_rindex[c];
        e.rhit        = nx_rhit[c];
        e.lookup      = nx_lookup[c];
        if (c == 0) exp_q0.push_back(e); else exp_q1.push_back(e);

        if (!rst_now) begin
          fire  = alloc_valid && e.alloc_ready;
          rslot = -1;
          fslot = -1;
          lk    = 1'b0;
          for (int i = 0; i < 8; i++) begin
            if (rslot < 0 && m_occ[c][i] && m_proc[c][i] && m_addr[c][i] == retire_addr) rslot = i;
            if (fslot < 0 && !m_occ[c][i]) fslot = i;
            if (m_occ[c][i] && m_addr[c][i] == lookup_addr) lk = 1'b1;
          end
          nx_merged[c] = fire && merge;
          nx_ack[c]    = retire_valid && (rslot >= 0);
          nx_err[c]    = retire_valid && (rslot < 0);
          nx_rindex[c] = nx_ack[c] ? m_idx[c][rslot] : 17'h0;
          nx_rhit[c]   = nx_ack[c] ? m_hit[c][rslot] : 1'b0;
          nx_lookup[c] = lk;
          if (fire && !merge && fslot >= 0) begin
            m_occ[c][fslot]  = 1'b1;
            m_proc[c][fslot] = 1'b0;
            m_addr[c][fslot] = alloc_addr;
            m_idx[c][fslot]  = alloc_index;
            m_hit[c][fslot]  = alloc_hit;
          end
          if (ifire) m_proc[c][pend] = 1'b1;
          if (nx_ack[c]) begin
            m_occ[c][rslot]  = 1'b0;
            m_proc[c][rslot] = 1'b0;
          end
        end
      end
    end

    @(negedge clk);
    #1;
    chk("queue_drain", 0, 64'(exp_q0.size()), 64'd0);
    chk("queue_drain", 1, 64'(exp_q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: every falling edge the DUTs present a full output view; pop and compare
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if ((c == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow dut%0d actual=empty expected=entry t=%0t", c, $time);
        end else begin
          e = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk("issue_valid",  c, 64'(issue_valid[c]),  64'(e.issue_valid));
          chk("issue_addr",   c, 64'(issue_addr[c]),   64'(e.issue_addr));
          chk("issue_index",  c, 64'(issue_index[c]),  64'(e.issue_index));
          chk("issue_slot",   c, 64'(issue_slot[c]),   64'(e.issue_slot));
          chk("occupancy",    c, 64'(occupancy[c]),    64'(e.occupancy));
          chk("full",         c, 64'(full[c]),         64'(e.full));
          chk("empty",        c, 64'(empty[c]),        64'(e.empty));
          chk("alloc_ready",  c, 64'(alloc_ready[c]),  64'(e.alloc_ready));
          chk("alloc_merged", c, 64'(alloc_merged[c]), 64'(e.merged));
          chk("retire_ack",   c, 64'(retire_ack[c]),   64'(e.ack));
          chk("retire_err",   c, 64'(retire_err[c]),   64'(e.err));
          chk("retire_index", c, 64'(retire_index[c]), 64'(e.rindex));
          chk("retire_hit",   c, 64'(retire_hit[c]),   64'(e.rhit));
          chk("lookup_hit",   c, 64'(lookup_hit[c]),   64'(e.lookup));
        end
      end
    end
  end

endmodule
